imem_ctrl: RTL and testbench

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_ctrl.sv | 135 +++++++++++++
 tb/tb_imem_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_ctrl.sv
// Instruction-fetch controller: routes each fetch to the tightly-coupled ITCM
// or to a single-beat AHB read, returning one instruction per valid pulse.
module imem_ctrl #(
  parameter logic [31:0] ITCM_BASE = 32'h0000_0000,
  parameter int unsigned ITCM_AW   = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        next_pc,
  output logic               instr_read_data_valid,
  output logic [31:0]        instr_read_data,
  output logic               addr_AHB,
  output logic               instr_bus_err,
  output logic               itcm_rd_en,
  output logic [ITCM_AW-1:0] itcm_addr,
  input  logic [31:0]        itcm_rdata,
  output logic [31:0]        HADDR,
  output logic [1:0]         HTRANS,
  output logic [2:0]         HSIZE,
  output logic [2:0]         HBURST,
  output logic               HWRITE,
  input  logic               HREADY,
  input  logic               HRESP,
  input  logic [31:0]        HRDATA
);

  typedef enum logic [1:0] {
    S_ITCM,
    S_AHB_ADDR,
    S_AHB_DATA,
    S_ERR
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        ahb_q, ahb_d;
  logic        err_q, err_d;
  logic        src_itcm_q, src_itcm_d;
  logic        hit;
  logic        unused_pc_lsb;

  assign hit           = (next_pc[31:ITCM_AW+2] == ITCM_BASE[31:ITCM_AW+2]);
  assign unused_pc_lsb = ^next_pc[1:0];
  assign itcm_addr     = next_pc[ITCM_AW+1:2];

  // ITCM data arrives un-registered in the valid cycle; it is captured
  // afterwards so the output keeps holding it once valid drops.
  assign instr_read_data       = (valid_q && src_itcm_q) ? itcm_rdata : rdata_q;
  assign instr_read_data_valid = valid_q;
  assign addr_AHB              = ahb_q;
  assign instr_bus_err         = err_q;

  assign HTRANS = (state_q == S_AHB_ADDR) ? 2'b10 : 2'b00;
  assign HADDR  = req_addr_q;
  assign HSIZE  = 3'b010;
  assign HBURST = '0;
  assign HWRITE = 1'b0;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    rdata_d    = (valid_q && src_itcm_q) ? itcm_rdata : rdata_q;
    valid_d    = 1'b0;
    ahb_d      = ahb_q;
    err_d      = 1'b0;
    src_itcm_d = 1'b0;
    itcm_rd_en = 1'b0;
    case (state_q)
      S_ITCM: begin
        if (hit) begin
          itcm_rd_en = 1'b1;
          valid_d    = 1'b1;
          ahb_d      = 1'b0;
          src_itcm_d = 1'b1;
        end else begin
          req_addr_d = next_pc;
          state_d    = S_AHB_ADDR;
        end
      end
      S_AHB_ADDR: begin
        if (HREADY) state_d = S_AHB_DATA;
      end
      S_AHB_DATA: begin
        if (HREADY) begin
          valid_d = 1'b1;
          ahb_d   = 1'b1;
          state_d = S_ITCM;
          if (HRESP) begin
            err_d   = 1'b1;
            rdata_d = NOP;
          end else begin
            rdata_d = HRDATA;
          end
        end else if (HRESP) begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        if (HREADY) begin
          valid_d = 1'b1;
          ahb_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = NOP;
          state_d = S_ITCM;
        end
      end
      default: state_d = S_ITCM;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q    <= S_ITCM;
      req_addr_q <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      ahb_q      <= 1'b0;
      err_q      <= 1'b0;
      src_itcm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      ahb_q      <= ahb_d;
      err_q      <= err_d;
      src_itcm_q <= src_itcm_d;
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: a per-cycle expectation table filled from
// transaction-level fetch rules, checked every cycle, plus literal spot checks.
module tb_imem_ctrl;

  localparam int unsigned AW   = 14;
  localparam logic [31:0] JUNK = 32'h0000_0100;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic [31:0]   next_pc;
  logic          instr_read_data_valid;
  logic [31:0]   instr_read_data;
  logic          addr_AHB;
  logic          instr_bus_err;
  logic          itcm_rd_en;
  logic [AW-1:0] itcm_addr;
  logic [31:0]   itcm_rdata;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic          HWRITE;
  logic          HREADY;
  logic          HRESP;
  logic [31:0]   HRDATA;

  imem_ctrl #(.ITCM_BASE(32'h0000_0000), .ITCM_AW(AW)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .next_pc(next_pc),
    .instr_read_data_valid(instr_read_data_valid), .instr_read_data(instr_read_data),
    .addr_AHB(addr_AHB), .instr_bus_err(instr_bus_err),
    .itcm_rd_en(itcm_rd_en), .itcm_addr(itcm_addr), .itcm_rdata(itcm_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWRITE(HWRITE),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 cpu_clk = ~cpu_clk;

  int npass = 0, ntot = 0, cyc = 0, nvalid = 0;
  bit chk_en = 1'b0;

  bit        exp_valid [512];
  bit [31:0] exp_data  [512];
  bit        exp_ahb   [512];
  bit        exp_err   [512];
  bit        exp_rden  [512];
  bit [13:0] exp_iaddr [512];
  bit [1:0]  exp_htrans[512];
  bit [31:0] exp_haddr [512];

  logic [31:0] itcm_mem [64];
  logic [31:0] m_data  = '0;
  logic        m_ahb   = 1'b0;
  logic [31:0] m_haddr = '0;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  // Synchronous ITCM: data appears the cycle after the read strobe.
  always @(posedge cpu_clk) if (itcm_rd_en) itcm_rdata <= itcm_mem[itcm_addr[5:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge cpu_clk) begin
    int c;
    if (chk_en) begin
      c = cyc;
      if (instr_read_data_valid) nvalid++;
      if (exp_valid[c]) begin
        chk("valid", {31'b0, instr_read_data_valid}, 32'd1);
        chk("data", instr_read_data, exp_data[c]);
        chk("addr_AHB", {31'b0, addr_AHB}, {31'b0, exp_ahb[c]});
        chk("bus_err", {31'b0, instr_bus_err}, {31'b0, exp_err[c]});
        m_data = exp_data[c];
        m_ahb  = exp_ahb[c];
      end else begin
        chk("valid_idle", {31'b0, instr_read_data_valid}, 32'd0);
        chk("data_hold", instr_read_data, m_data);
        chk("addr_AHB_hold", {31'b0, addr_AHB}, {31'b0, m_ahb});
        chk("bus_err_idle", {31'b0, instr_bus_err}, 32'd0);
      end
      chk("htrans", {30'b0, HTRANS}, {30'b0, exp_htrans[c]});
      if (exp_htrans[c] == 2'b10) begin
        chk("haddr", HADDR, exp_haddr[c]);
        chk("hsize", {29'b0, HSIZE}, 32'd2);
        chk("hburst", {29'b0, HBURST}, 32'd0);
        chk("hwrite", {31'b0, HWRITE}, 32'd0);
        m_haddr = exp_haddr[c];
      end else begin
        chk("haddr_hold", HADDR, m_haddr);
      end
      chk("itcm_rd_en", {31'b0, itcm_rd_en}, {31'b0, exp_rden[c]});
      if (exp_rden[c]) chk("itcm_addr", {18'b0, itcm_addr}, {18'b0, exp_iaddr[c]});
    end
  end

  task automatic next_cycle();
    @(posedge cpu_clk);
    #1;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'hDEAD_BEEF;
  endtask

  task automatic issue_itcm(input logic [31:0] a);
    next_pc          = a;
    exp_rden[cyc]    = 1'b1;
    exp_iaddr[cyc]   = a[15:2];
    exp_valid[cyc+1] = 1'b1;
    exp_data[cyc+1]  = itcm_mem[a[7:2]];
    exp_ahb[cyc+1]   = 1'b0;
    exp_err[cyc+1]   = 1'b0;
  endtask

  task automatic itcm_fetch(input logic [31:0] a);
    next_cycle();
    issue_itcm(a);
  endtask

  // Single AHB read: aw address-phase waits, dw data-phase waits, optional
  // two-cycle ERROR response; result is due the cycle after completion.
  task automatic ahb_fetch(input logic [31:0] a, input logic [31:0] d,
                           input int aw, input int dw, input bit err);
    next_cycle();
    next_pc = a;
    for (int i = 0; i <= aw; i++) begin
      next_cycle();
      next_pc         = JUNK;
      HREADY          = (i == aw);
      exp_htrans[cyc] = 2'b10;
      exp_haddr[cyc]  = a;
    end
    for (int i = 0; i < dw; i++) begin
      next_cycle();
      next_pc = JUNK;
      HREADY  = 1'b0;
    end
    if (err) begin
      next_cycle();
      next_pc = JUNK;
      HREADY  = 1'b0;
      HRESP   = 1'b1;
    end
    next_cycle();
    next_pc          = JUNK;
    HREADY           = 1'b1;
    HRESP            = err;
    HRDATA           = err ? 32'hFFFF_FFFF : d;
    exp_valid[cyc+1] = 1'b1;
    exp_data[cyc+1]  = err ? 32'h0000_0013 : d;
    exp_ahb[cyc+1]   = 1'b1;
    exp_err[cyc+1]   = err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) itcm_mem[i] = 32'h0100_0000 | i;
    itcm_mem[0] = 32'h0000_000A;
    itcm_mem[1] = 32'h0000_000B;
    itcm_mem[2] = 32'h0000_000C;
    cpu_rst = 1'b1;
    next_pc = '0;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    HRDATA  = '0;

    repeat (2) @(posedge cpu_clk);
    #1;
    chk("rst_valid", {31'b0, instr_read_data_valid}, 32'd0);
    chk("rst_data", instr_read_data, 32'h0);
    chk("rst_htrans", {30'b0, HTRANS}, 32'd0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hsize", {29'b0, HSIZE}, 32'd2);
    chk("rst_addr_AHB", {31'b0, addr_AHB}, 32'd0);
    chk("rst_bus_err", {31'b0, instr_bus_err}, 32'd0);

    cpu_rst = 1'b0;
    chk_en  = 1'b1;
    issue_itcm(32'h0);

    itcm_fetch(32'h0);
    itcm_fetch(32'h4);
    @(negedge cpu_clk) chk("stream_A", instr_read_data, 32'h0000_000A);
    itcm_fetch(32'h8);
    @(negedge cpu_clk) chk("stream_B", instr_read_data, 32'h0000_000B);

    ahb_fetch(32'h2000_0000, 32'h1234_5678, 0, 0, 1'b0);
    itcm_fetch(32'h10);
    @(negedge cpu_clk) begin
      chk("ahb0_data", instr_read_data, 32'h1234_5678);
      chk("ahb0_src", {31'b0, addr_AHB}, 32'd1);
    end

    itcm_fetch(32'h14);
    ahb_fetch(32'h2000_0040, 32'hCAFE_F00D, 0, 3, 1'b0);
    itcm_fetch(32'h18);
    @(negedge cpu_clk) chk("ahb_wait_data", instr_read_data, 32'hCAFE_F00D);

    ahb_fetch(32'h4000_0000, 32'h0, 0, 1, 1'b1);
    itcm_fetch(32'h1C);
    @(negedge cpu_clk) begin
      chk("err_nop", instr_read_data, 32'h0000_0013);
      chk("err_flag", {31'b0, instr_bus_err}, 32'd1);
    end

    itcm_fetch(32'h20);
    ahb_fetch(32'h8000_0004, 32'h0BAD_BEEF, 2, 0, 1'b0);
    itcm_fetch(32'h24);
    itcm_fetch(32'h28);

    next_cycle();
    next_pc = 32'h3000_0000;
    next_cycle();
    next_pc         = JUNK;
    exp_htrans[cyc] = 2'b10;
    exp_haddr[cyc]  = 32'h3000_0000;
    next_cycle();
    HREADY = 1'b0;
    @(negedge cpu_clk);
    #2;
    chk_en  = 1'b0;
    cpu_rst = 1'b1;
    #1;
    chk("rstmid_htrans", {30'b0, HTRANS}, 32'd0);
    chk("rstmid_valid", {31'b0, instr_read_data_valid}, 32'd0);
    chk("rstmid_data", instr_read_data, 32'h0);
    chk("rstmid_haddr", HADDR, 32'h0);
    chk("valid_count", nvalid, 32'd15);

    @(posedge cpu_clk);
    #1;
    next_pc = 32'h3000_0000;
    HREADY  = 1'b1;
    cpu_rst = 1'b0;
    @(negedge cpu_clk) begin
      chk("post_rst_valid0", {31'b0, instr_read_data_valid}, 32'd0);
      chk("post_rst_htrans0", {30'b0, HTRANS}, 32'd0);
    end
    next_cycle();
    @(negedge cpu_clk) begin
      chk("post_rst_valid1", {31'b0, instr_read_data_valid}, 32'd0);
      chk("post_rst_nonseq", {30'b0, HTRANS}, 32'd2);
    end
    next_cycle();
    @(negedge cpu_clk) chk("post_rst_valid2", {31'b0, instr_read_data_valid}, 32'd0);
    next_cycle();
    @(negedge cpu_clk) begin
      chk("post_rst_return", {31'b0, instr_read_data_valid}, 32'd1);
      chk("post_rst_data", instr_read_data, 32'hDEAD_BEEF);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
